// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: run/step arbitration, load-use stall, branch flush,
// and HALT drain with completion handshake to the debug unit.
module pipeline_ctrl #(
  parameter int unsigned RBITS = 5,
  parameter int unsigned CBITS = 32,
  parameter int unsigned DRAIN = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_halt_instr,
  input  logic [RBITS-1:0] ID_rs,
  input  logic [RBITS-1:0] ID_rt,
  input  logic [RBITS-1:0] EX_rt,
  input  logic             EX_memread,
  input  logic             i_branch_taken,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_pipe_en,
  output logic [2:0]       o_state,
  output logic             o_done,
  output logic [CBITS-1:0] o_cycles
);

  localparam int unsigned DW = $clog2(DRAIN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic            step_q;
  logic            active;
  logic            lu;
  logic            br;
  logic            hl;

  // Hazard terms; only meaningful while instructions are advancing.
  always_comb begin
    active = (state == S_RUN) || (state == S_STEP);
    lu     = active && EX_memread && (EX_rt != '0) &&
             ((EX_rt == ID_rs) || (EX_rt == ID_rt));
    br     = active && i_branch_taken && !lu;
    hl     = active && i_halt_instr && !lu;
  end

  // Per-cycle stage controls; everything is held low while reset is asserted.
  always_comb begin
    o_pc_en       = 1'b0;
    o_ifid_en     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_pipe_en     = 1'b0;
    o_done        = 1'b0;
    if (!i_rst) begin
      case (state)
        S_RUN, S_STEP: begin
          o_pipe_en = 1'b1;
          if (lu) begin
            o_idex_bubble = 1'b1;
          end else if (hl) begin
            // HALT is turned into a NOP as it moves into ID/EX.
            o_ifid_en    = 1'b1;
            o_ifid_flush = 1'b1;
          end else begin
            o_pc_en      = 1'b1;
            o_ifid_en    = 1'b1;
            o_ifid_flush = br;
          end
        end
        S_DRAIN: begin
          o_idex_bubble = 1'b1;
          o_pipe_en     = 1'b1;
        end
        S_DONE:  o_done = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_state = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      step_q    <= 1'b0;
      o_cycles  <= '0;
    end else begin
      step_q <= i_step;
      if (o_pipe_en && (o_cycles != '1)) o_cycles <= o_cycles + CBITS'(1);
      case (state)
        S_IDLE: begin
          if (i_run)                 state <= S_RUN;
          else if (i_step && !step_q) state <= S_STEP;
        end
        S_RUN: begin
          if (hl) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(DRAIN);
          end else if (!i_run) begin
            state <= S_IDLE;
          end
        end
        S_STEP: begin
          if (hl) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(DRAIN);
          end else begin
            state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) state <= S_DONE;
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Vector-table bench for pipeline_ctrl with a scoreboard queue of expected outputs,
// plus a small-counter instance for saturation and a bounded HALT-latency sequence.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, step, halt, memread, branch;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en, done;
  logic [2:0] state;
  logic [31:0] cycles;
  logic       s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_pipe_en, s_done;
  logic [2:0] s_state;
  logic [1:0] s_cycles;

  always #5 clk = ~clk;

  pipeline_ctrl #(.RBITS(5), .CBITS(32), .DRAIN(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_step(step), .i_halt_instr(halt),
    .ID_rs(id_rs), .ID_rt(id_rt), .EX_rt(ex_rt), .EX_memread(memread),
    .i_branch_taken(branch), .o_pc_en(pc_en), .o_ifid_en(ifid_en),
    .o_ifid_flush(ifid_flush), .o_idex_bubble(idex_bubble), .o_pipe_en(pipe_en),
    .o_state(state), .o_done(done), .o_cycles(cycles)
  );

  // Same stimulus, 2-bit cycle counter to exercise saturation.
  pipeline_ctrl #(.RBITS(5), .CBITS(2), .DRAIN(3)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_step(step), .i_halt_instr(halt),
    .ID_rs(id_rs), .ID_rt(id_rt), .EX_rt(ex_rt), .EX_memread(memread),
    .i_branch_taken(branch), .o_pc_en(s_pc_en), .o_ifid_en(s_ifid_en),
    .o_ifid_flush(s_ifid_flush), .o_idex_bubble(s_idex_bubble), .o_pipe_en(s_pipe_en),
    .o_state(s_state), .o_done(s_done), .o_cycles(s_cycles)
  );

  typedef struct packed {
    logic       rst, run, step, halt;
    logic [4:0] rs, rt, exrt;
    logic       mr, br;
  } in_t;

  typedef struct packed {
    logic        pc, ifid, flush, bub, pipe;
    logic [2:0]  st;
    logic        dn;
    logic [31:0] cyc;
  } out_t;

  localparam logic [4:0] PZ = 5'b00000;
  localparam logic [4:0] PN = 5'b11001;
  localparam logic [4:0] PS = 5'b00011;
  localparam logic [4:0] PB = 5'b11101;
  localparam logic [4:0] PH = 5'b01101;

  in_t  vin[$];
  out_t vexp[$];
  out_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic in_t mi(bit r, bit ru, bit st, bit h, logic [4:0] rs, logic [4:0] rt,
                             logic [4:0] exrt, bit mr, bit br);
    in_t v;
    v.rst = r; v.run = ru; v.step = st; v.halt = h;
    v.rs = rs; v.rt = rt; v.exrt = exrt; v.mr = mr; v.br = br;
    return v;
  endfunction

  function automatic out_t mo(logic [4:0] p, logic [2:0] st, bit dn, int unsigned cyc);
    out_t o;
    {o.pc, o.ifid, o.flush, o.bub, o.pipe} = p;
    o.st = st; o.dn = dn; o.cyc = 32'(cyc);
    return o;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vin.push_back(i);
    vexp.push_back(o);
  endtask

  task automatic drive(input in_t v);
    rst = v.rst; run = v.run; step = v.step; halt = v.halt;
    id_rs = v.rs; id_rt = v.rt; ex_rt = v.exrt; memread = v.mr; branch = v.br;
  endtask

  function automatic out_t got();
    out_t o;
    o.pc = pc_en; o.ifid = ifid_en; o.flush = ifid_flush; o.bub = idex_bubble;
    o.pipe = pipe_en; o.st = state; o.dn = done; o.cyc = cycles;
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got pc/ifid/fl/bub/pipe=%b%b%b%b%b st=%0d done=%b cyc=%0d, want %b%b%b%b%b st=%0d done=%b cyc=%0d",
               name, act.pc, act.ifid, act.flush, act.bub, act.pipe, act.st, act.dn, act.cyc,
               want.pc, want.ifid, want.flush, want.bub, want.pipe, want.st, want.dn, want.cyc);
    end
  endtask

  task automatic check_sat(input string name, input logic [31:0] full);
    logic [1:0] want;
    want = (full > 32'd3) ? 2'd3 : full[1:0];
    checks++;
    if (s_cycles !== want) begin
      errors++;
      $display("FAIL %s: got sat_cycles=%0d, want %0d", name, s_cycles, want);
    end
  endtask

  initial begin
    out_t e;
    int   n;
    bit   seen;

    // Reset and a 10-cycle free run.
    add(mi(1,0,0,0,0,0,0,0,0), mo(PZ,0,0,0));
    add(mi(0,1,0,0,0,0,0,0,0), mo(PZ,0,0,0));
    for (int c = 0; c < 10; c++) add(mi(0,1,0,0,0,0,0,0,0), mo(PN,1,0,c));
    // Load-use, x0 destination, non-matching registers, branch, branch under stall, halt under stall.
    add(mi(0,1,0,0,5,0,5,1,0), mo(PS,1,0,10));
    add(mi(0,1,0,0,0,5,5,1,0), mo(PS,1,0,11));
    add(mi(0,1,0,0,0,0,0,1,0), mo(PN,1,0,12));
    add(mi(0,1,0,0,6,7,5,1,0), mo(PN,1,0,13));
    add(mi(0,1,0,0,0,0,0,0,1), mo(PB,1,0,14));
    add(mi(0,1,0,0,5,0,5,1,1), mo(PS,1,0,15));
    add(mi(0,1,0,1,0,3,3,1,0), mo(PS,1,0,16));
    add(mi(0,0,0,0,0,0,0,0,0), mo(PN,1,0,17));
    add(mi(0,0,0,0,0,0,0,0,0), mo(PZ,0,0,18));
    // Step held high, then re-armed.
    add(mi(0,0,1,0,0,0,0,0,0), mo(PZ,0,0,18));
    add(mi(0,0,1,0,0,0,0,0,0), mo(PN,2,0,18));
    for (int c = 0; c < 3; c++) add(mi(0,0,1,0,0,0,0,0,0), mo(PZ,0,0,19));
    add(mi(0,0,0,0,0,0,0,0,0), mo(PZ,0,0,19));
    add(mi(0,0,1,0,0,0,0,0,0), mo(PZ,0,0,19));
    add(mi(0,0,0,0,0,0,0,0,0), mo(PN,2,0,19));
    add(mi(0,0,0,0,0,0,0,0,0), mo(PZ,0,0,20));
    // A stalled step still consumes the step.
    add(mi(0,0,1,0,0,0,0,0,0), mo(PZ,0,0,20));
    add(mi(0,0,0,0,4,0,4,1,0), mo(PS,2,0,20));
    add(mi(0,0,0,0,0,0,0,0,0), mo(PZ,0,0,21));
    // HALT with run dropping the same cycle, drain ignores run/step, DONE sticks.
    add(mi(0,1,0,0,0,0,0,0,0), mo(PZ,0,0,21));
    add(mi(0,1,0,0,0,0,0,0,0), mo(PN,1,0,21));
    add(mi(0,0,0,1,0,0,0,0,0), mo(PH,1,0,22));
    add(mi(0,1,0,0,0,0,0,0,0), mo(PS,3,0,23));
    add(mi(0,1,1,0,0,0,0,0,0), mo(PS,3,0,24));
    add(mi(0,1,0,0,0,0,0,0,0), mo(PS,3,0,25));
    add(mi(0,1,0,0,0,0,0,0,0), mo(PZ,4,1,26));
    add(mi(0,1,1,0,0,0,0,0,0), mo(PZ,4,1,26));
    // Reset out of DONE, then reset during the second drain cycle.
    add(mi(1,0,0,0,0,0,0,0,0), mo(PZ,4,0,26));
    add(mi(0,1,0,0,0,0,0,0,0), mo(PZ,0,0,0));
    add(mi(0,1,0,1,0,0,0,0,0), mo(PH,1,0,0));
    add(mi(0,0,0,0,0,0,0,0,0), mo(PS,3,0,1));
    add(mi(1,0,0,0,0,0,0,0,0), mo(PZ,3,0,2));
    add(mi(0,0,0,0,0,0,0,0,0), mo(PZ,0,0,0));
    // HALT arriving during a single step.
    add(mi(0,0,1,1,0,0,0,0,0), mo(PZ,0,0,0));
    add(mi(0,0,1,1,0,0,0,0,0), mo(PH,2,0,0));
    for (int c = 1; c <= 3; c++) add(mi(0,0,0,0,0,0,0,0,0), mo(PS,3,0,c));
    add(mi(0,0,0,0,0,0,0,0,0), mo(PZ,4,1,4));

    drive(mi(1,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);

    for (int k = 0; k < vin.size(); k++) begin
      @(posedge clk); #1;
      drive(vin[k]);
      exp_q.push_back(vexp[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("vec%0d", k), got(), e);
      check_sat($sformatf("sat%0d", k), e.cyc);
    end

    // HALT-to-done latency with a bounded wait.
    @(posedge clk); #1 drive(mi(1,0,0,0,0,0,0,0,0));
    @(posedge clk); #1 drive(mi(0,1,0,0,0,0,0,0,0));
    @(posedge clk); #1 drive(mi(0,1,0,1,0,0,0,0,0));
    exp_q.push_back(mo(PZ,4,1,4));
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1 drive(mi(0,0,0,0,0,0,0,0,0));
      n++;
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL halt_latency: got %0d cycles to done, want 4", n);
    end
    e = exp_q.pop_front();
    check("halt_done", got(), e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
